// File: rtl/lsu_pkg.sv
// Shared FSM encoding, width defaults and byte-lane constants for the load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: LSU_ADDR_W / LSU_DATA_W defaults, LSU_BYTE_W, lane selectors
// LANE_LO / LANE_HI, and the lsu_state_e state enum.
package lsu_pkg;

    localparam int LSU_ADDR_W = 16;
    localparam int LSU_DATA_W = 16;
    localparam int LSU_BYTE_W = 8;

    // Byte-lane selector values: LO = bits 7:0, HI = bits 15:8
    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_RDW  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } lsu_state_e;

endpackage

// File: rtl/lsu_byte_merge.sv
// Byte-lane extract (with optional sign extension) and byte-lane merge for 16-bit words.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: word (memory word), bval (byte to insert), bsel (lane), sext (sign-extend
// the extracted byte), extracted (selected lane widened to a word), merged (word
// with the selected lane replaced by bval).
module lsu_byte_merge
    import lsu_pkg::*;
(
    input  logic [LSU_DATA_W-1:0] word,
    input  logic [LSU_BYTE_W-1:0] bval,
    input  logic                  bsel,
    input  logic                  sext,
    output logic [LSU_DATA_W-1:0] extracted,
    output logic [LSU_DATA_W-1:0] merged
);

    logic [LSU_BYTE_W-1:0] lane;

    assign lane      = (bsel == LANE_HI) ? word[15:8] : word[7:0];
    assign extracted = {{(LSU_DATA_W-LSU_BYTE_W){sext & lane[LSU_BYTE_W-1]}}, lane};
    assign merged    = (bsel == LANE_HI) ? {bval, word[7:0]} : {word[15:8], bval};

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sequences word/byte loads and stores onto a 1-cycle-latency sync memory.
// Latency: word store 2, load 3, byte store (read-modify-write) 4 cycles from acceptance to Resp_valid.
// Backpressure: Req_ready high only in IDLE; no response backpressure.
//
// Ports: Clk, Rst_n (async active-low); request Req_valid/Req_ready/Req_write/Req_byte/
// Req_bsel/Req_signed/Req_addr/Req_wdata; response Resp_valid/Resp_rdata;
// memory Mem_addr/Mem_wdata/Mem_read/Mem_write/Mem_rdata.
// Build option: define LSU_BYTE_OPS_EN to enable byte loads/stores; otherwise the
// byte controls are ignored and every access is a full word.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DATA_W = LSU_DATA_W
)(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req_valid,
    output logic              Req_ready,
    input  logic              Req_write,
    input  logic              Req_byte,
    input  logic              Req_bsel,
    input  logic              Req_signed,
    input  logic [ADDR_W-1:0] Req_addr,
    input  logic [DATA_W-1:0] Req_wdata,
    output logic              Resp_valid,
    output logic [DATA_W-1:0] Resp_rdata,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic [DATA_W-1:0] Mem_wdata,
    output logic              Mem_read,
    output logic              Mem_write,
    input  logic [DATA_W-1:0] Mem_rdata
);

    lsu_state_e        state;
    logic [DATA_W-1:0] lane_word;
    logic [DATA_W-1:0] lane_merged;
    logic              m_bsel;
    logic              m_sext;

    // Mem_wdata doubles as the store-data register; its low byte is the byte to insert.
    lsu_byte_merge u_merge (
        .word      (Mem_rdata),
        .bval      (Mem_wdata[7:0]),
        .bsel      (m_bsel),
        .sext      (m_sext),
        .extracted (lane_word),
        .merged    (lane_merged)
    );

`ifdef LSU_BYTE_OPS_EN
    logic write_q;
    logic byte_q;
    logic bsel_q;
    logic signed_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            write_q  <= 1'b0;
            byte_q   <= 1'b0;
            bsel_q   <= 1'b0;
            signed_q <= 1'b0;
        end else if (state == ST_IDLE && Req_valid) begin
            write_q  <= Req_write;
            byte_q   <= Req_byte;
            bsel_q   <= Req_bsel;
            signed_q <= Req_signed;
        end
    end

    assign m_bsel = bsel_q;
    assign m_sext = signed_q;
`else
    logic unused_byte_ctl;

    assign m_bsel          = 1'b0;
    assign m_sext          = 1'b0;
    assign unused_byte_ctl = ^{Req_byte, Req_bsel, Req_signed, lane_word, lane_merged};
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= ST_IDLE;
            Mem_addr   <= '0;
            Mem_wdata  <= '0;
            Resp_rdata <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (Req_valid) begin
                        Mem_addr  <= Req_addr;
                        Mem_wdata <= Req_wdata;
`ifdef LSU_BYTE_OPS_EN
                        // Byte stores must read the word first to preserve the other lane.
                        state <= (Req_write && !Req_byte) ? ST_WR : ST_RD;
`else
                        state <= Req_write ? ST_WR : ST_RD;
`endif
                    end
                end
                ST_RD: state <= ST_RDW;
                ST_RDW: begin
`ifdef LSU_BYTE_OPS_EN
                    // Only byte stores reach RDW with write set: latch the merged word.
                    if (write_q) begin
                        Mem_wdata <= lane_merged;
                        state     <= ST_WR;
                    end else begin
                        Resp_rdata <= byte_q ? lane_word : Mem_rdata;
                        state      <= ST_DONE;
                    end
`else
                    Resp_rdata <= Mem_rdata;
                    state      <= ST_DONE;
`endif
                end
                ST_WR:   state <= ST_DONE;
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobes decode from the state register only, so they are mutually exclusive.
    assign Req_ready  = (state == ST_IDLE);
    assign Mem_read   = (state == ST_RD);
    assign Mem_write  = (state == ST_WR);
    assign Resp_valid = (state == ST_DONE);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a synchronous memory model and response scoreboard.
// Latency: observes per-operation strobe timing relative to the accepting clock edge.
// Backpressure: holds Req_valid across busy periods to exercise Req_ready.
module tb_load_store_unit;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Req_valid;
    logic        Req_ready;
    logic        Req_write;
    logic        Req_byte;
    logic        Req_bsel;
    logic        Req_signed;
    logic [15:0] Req_addr;
    logic [15:0] Req_wdata;
    logic        Resp_valid;
    logic [15:0] Resp_rdata;
    logic [15:0] Mem_addr;
    logic [15:0] Mem_wdata;
    logic        Mem_read;
    logic        Mem_write;
    logic [15:0] Mem_rdata = 16'h0000;

    always #5 Clk = ~Clk;

    load_store_unit #(.ADDR_W(16), .DATA_W(16)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Req_valid  (Req_valid),
        .Req_ready  (Req_ready),
        .Req_write  (Req_write),
        .Req_byte   (Req_byte),
        .Req_bsel   (Req_bsel),
        .Req_signed (Req_signed),
        .Req_addr   (Req_addr),
        .Req_wdata  (Req_wdata),
        .Resp_valid (Resp_valid),
        .Resp_rdata (Resp_rdata),
        .Mem_addr   (Mem_addr),
        .Mem_wdata  (Mem_wdata),
        .Mem_read   (Mem_read),
        .Mem_write  (Mem_write),
        .Mem_rdata  (Mem_rdata)
    );

    // Synchronous memory model; preload port lets the bench seed words.
    logic [15:0] mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = 8'h00;
    logic [15:0] pl_dat = 16'h0000;
    int          cyc = 0;

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (pl_en) mem[pl_addr] <= pl_dat;
        if (Mem_write) mem[Mem_addr[7:0]] <= Mem_wdata;
        if (Mem_read) Mem_rdata <= mem[Mem_addr[7:0]];
    end

    typedef struct {
        bit          is_load;
        logic [15:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   acc_mark = 0;
    int   rd_rel = -1;
    int   wr_rel = -1;
    int   resp_rel = -1;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    int   resp_cnt = 0;
    int   both_cnt = 0;

    function automatic exp_t mk(input bit ld, input logic [15:0] d);
        exp_t e;
        e.is_load = ld;
        e.rdata   = d;
        return e;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Mem_read && Mem_write) both_cnt++;
            if (Mem_read) begin
                rd_cnt++;
                if (rd_rel < 0) rd_rel = cyc - acc_mark;
            end
            if (Mem_write) begin
                wr_cnt++;
                if (wr_rel < 0) wr_rel = cyc - acc_mark;
            end
            if (Resp_valid) begin
                resp_cnt++;
                resp_rel = cyc - acc_mark;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL resp_unexpected: Resp_valid at cycle %0d, nothing outstanding", cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.is_load) begin
                        n_checks++;
                        if (Resp_rdata !== e.rdata) begin
                            n_fail++;
                            $display("FAIL load_rdata: got %h expected %h", Resp_rdata, e.rdata);
                        end
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        @(negedge Clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_dat  = d;
        @(negedge Clk);
        pl_en   = 1'b0;
    endtask

    // Presents one request, waits (bounded) for acceptance, returns in cycle 1.
    task automatic issue(input logic w, input logic b, input logic bs, input logic sg,
                         input logic [15:0] a, input logic [15:0] d);
        int guard;
        guard = 0;
        @(negedge Clk);
        Req_write  = w;
        Req_byte   = b;
        Req_bsel   = bs;
        Req_signed = sg;
        Req_addr   = a;
        Req_wdata  = d;
        Req_valid  = 1'b1;
        while (!Req_ready && guard < 20) begin
            @(negedge Clk);
            guard++;
        end
        if (!Req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: Req_ready got %b expected 1 within 20 cycles", Req_ready);
        end
        acc_mark = cyc;
        rd_rel   = -1;
        wr_rel   = -1;
        resp_rel = -1;
        rd_cnt   = 0;
        wr_cnt   = 0;
        resp_cnt = 0;
        @(negedge Clk);
        Req_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle(2);
        n_checks++; if (Req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", Req_ready); end
        n_checks++; if (Resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", Resp_valid); end
        n_checks++; if (Resp_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0000", Resp_rdata); end
        n_checks++; if (Mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read: got %b expected 0", Mem_read); end
        n_checks++; if (Mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write: got %b expected 0", Mem_write); end
        n_checks++; if (Mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0000", Mem_addr); end
        n_checks++; if (Mem_wdata !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_wdata: got %h expected 0000", Mem_wdata); end
        Rst_n = 1'b1;
    endtask

    task automatic test_word_store();
        sb.push_back(mk(1'b0, 16'h0000));
        issue(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'hBEEF);
        idle(6);
        n_checks++; if (wr_rel !== 1) begin n_fail++; $display("FAIL wst_write_cycle: got %0d expected 1", wr_rel); end
        n_checks++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL wst_write_count: got %0d expected 1", wr_cnt); end
        n_checks++; if (rd_cnt !== 0) begin n_fail++; $display("FAIL wst_read_count: got %0d expected 0", rd_cnt); end
        n_checks++; if (resp_rel !== 2) begin n_fail++; $display("FAIL wst_resp_cycle: got %0d expected 2", resp_rel); end
        n_checks++; if (mem[8'h10] !== 16'hBEEF) begin n_fail++; $display("FAIL wst_mem: got %h expected beef", mem[8'h10]); end
    endtask

    task automatic test_word_load();
        sb.push_back(mk(1'b1, 16'hBEEF));
        issue(1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        idle(6);
        n_checks++; if (rd_rel !== 1) begin n_fail++; $display("FAIL wld_read_cycle: got %0d expected 1", rd_rel); end
        n_checks++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL wld_write_count: got %0d expected 0", wr_cnt); end
        n_checks++; if (resp_rel !== 3) begin n_fail++; $display("FAIL wld_resp_cycle: got %0d expected 3", resp_rel); end
        n_checks++; if (Resp_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL wld_rdata_held: got %h expected beef", Resp_rdata); end
    endtask

`ifdef LSU_BYTE_OPS_EN
    task automatic test_byte_load();
        bit          bs_t [4];
        bit          sg_t [4];
        logic [15:0] ex_t [4];
        bs_t = '{1'b1, 1'b0, 1'b1, 1'b0};
        sg_t = '{1'b1, 1'b0, 1'b0, 1'b1};
        ex_t = '{16'hFF80, 16'h00F0, 16'h0080, 16'hFFF0};
        preload(8'h20, 16'h80F0);
        for (int i = 0; i < 4; i++) begin
            sb.push_back(mk(1'b1, ex_t[i]));
            issue(1'b0, 1'b1, bs_t[i], sg_t[i], 16'h0020, 16'h0000);
            idle(5);
            n_checks++; if (resp_rel !== 3) begin n_fail++; $display("FAIL bld_resp_cycle[%0d]: got %0d expected 3", i, resp_rel); end
        end
    endtask

    task automatic test_byte_store();
        preload(8'h30, 16'h1234);
        sb.push_back(mk(1'b0, 16'h0000));
        issue(1'b1, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h00AB);
        idle(6);
        n_checks++; if (rd_rel !== 1) begin n_fail++; $display("FAIL bst_read_cycle: got %0d expected 1", rd_rel); end
        n_checks++; if (wr_rel !== 3) begin n_fail++; $display("FAIL bst_write_cycle: got %0d expected 3", wr_rel); end
        n_checks++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL bst_write_count: got %0d expected 1", wr_cnt); end
        n_checks++; if (resp_rel !== 4) begin n_fail++; $display("FAIL bst_resp_cycle: got %0d expected 4", resp_rel); end
        n_checks++; if (mem[8'h30] !== 16'h12AB) begin n_fail++; $display("FAIL bst_mem_lo: got %h expected 12ab", mem[8'h30]); end
        sb.push_back(mk(1'b0, 16'h0000));
        issue(1'b1, 1'b1, 1'b1, 1'b0, 16'h0030, 16'h77CD);
        idle(6);
        n_checks++; if (mem[8'h30] !== 16'hCDAB) begin n_fail++; $display("FAIL bst_mem_hi: got %h expected cdab", mem[8'h30]); end
    endtask

    task automatic test_reset_mid_op();
        preload(8'h34, 16'h5678);
        issue(1'b1, 1'b1, 1'b1, 1'b0, 16'h0034, 16'h0011);
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        n_checks++; if (Req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", Req_ready); end
        n_checks++; if (Mem_write !== 1'b0) begin n_fail++; $display("FAIL rmid_mem_write: got %b expected 0", Mem_write); end
        @(negedge Clk);
        n_checks++; if (Req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_hold: got %b expected 1", Req_ready); end
        Rst_n = 1'b1;
        idle(6);
        n_checks++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL rmid_write_count: got %0d expected 0", wr_cnt); end
        n_checks++; if (resp_cnt !== 0) begin n_fail++; $display("FAIL rmid_resp_count: got %0d expected 0", resp_cnt); end
        n_checks++; if (mem[8'h34] !== 16'h5678) begin n_fail++; $display("FAIL rmid_mem: got %h expected 5678", mem[8'h34]); end
    endtask
`else
    task automatic test_no_byte_ops();
        sb.push_back(mk(1'b0, 16'h0000));
        issue(1'b1, 1'b1, 1'b1, 1'b1, 16'h0040, 16'h00AB);
        idle(6);
        n_checks++; if (rd_cnt !== 0) begin n_fail++; $display("FAIL nb_read_count: got %0d expected 0", rd_cnt); end
        n_checks++; if (wr_rel !== 1) begin n_fail++; $display("FAIL nb_write_cycle: got %0d expected 1", wr_rel); end
        n_checks++; if (resp_rel !== 2) begin n_fail++; $display("FAIL nb_resp_cycle: got %0d expected 2", resp_rel); end
        n_checks++; if (mem[8'h40] !== 16'h00AB) begin n_fail++; $display("FAIL nb_mem: got %h expected 00ab", mem[8'h40]); end
        preload(8'h20, 16'h80F0);
        sb.push_back(mk(1'b1, 16'h80F0));
        issue(1'b0, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h0000);
        idle(6);
        n_checks++; if (resp_rel !== 3) begin n_fail++; $display("FAIL nb_load_resp_cycle: got %0d expected 3", resp_rel); end
    endtask

    task automatic test_reset_mid_op();
        issue(1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        n_checks++; if (Req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", Req_ready); end
        n_checks++; if (Resp_rdata !== 16'h0000) begin n_fail++; $display("FAIL rmid_rdata: got %h expected 0000", Resp_rdata); end
        @(negedge Clk);
        n_checks++; if (Req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_hold: got %b expected 1", Req_ready); end
        Rst_n = 1'b1;
        idle(6);
        n_checks++; if (resp_cnt !== 0) begin n_fail++; $display("FAIL rmid_resp_count: got %0d expected 0", resp_cnt); end
        n_checks++; if (rd_cnt !== 1) begin n_fail++; $display("FAIL rmid_read_count: got %0d expected 1", rd_cnt); end
    endtask
`endif

    task automatic test_back_to_back();
        int acc[$];
        int busy;
        int gap;
        busy = 0;
        preload(8'h50, 16'hA5C3);
        sb.push_back(mk(1'b1, 16'hBEEF));
        sb.push_back(mk(1'b1, 16'hA5C3));
        @(negedge Clk);
        Req_write  = 1'b0;
        Req_byte   = 1'b0;
        Req_bsel   = 1'b0;
        Req_signed = 1'b0;
        Req_addr   = 16'h0010;
        Req_wdata  = 16'h0000;
        Req_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge Clk);
            if (acc.size() == 2) Req_valid = 1'b0;
            else if (acc.size() == 1) Req_addr = 16'h0050;
            if (Req_valid && Req_ready) begin
                acc.push_back(cyc);
                if (acc.size() == 1) begin
                    acc_mark = cyc;
                    resp_cnt = 0;
                end
            end else if (Req_valid) begin
                busy++;
            end
        end
        Req_valid = 1'b0;
        gap = (acc.size() == 2) ? (acc[1] - acc[0]) : -1;
        n_checks++; if (acc.size() !== 2) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 2", acc.size()); end
        n_checks++; if (gap !== 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 4", gap); end
        n_checks++; if (busy !== 3) begin n_fail++; $display("FAIL b2b_ready_low: got %0d expected 3", busy); end
        n_checks++; if (resp_cnt !== 2) begin n_fail++; $display("FAIL b2b_resp_count: got %0d expected 2", resp_cnt); end
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL rd_wr_overlap: got %0d expected 0", both_cnt); end
        n_checks++; if (Resp_rdata !== 16'hA5C3) begin n_fail++; $display("FAIL b2b_rdata_held: got %h expected a5c3", Resp_rdata); end
    endtask

    initial begin
        Rst_n      = 1'b1;
        Req_valid  = 1'b0;
        Req_write  = 1'b0;
        Req_byte   = 1'b0;
        Req_bsel   = 1'b0;
        Req_signed = 1'b0;
        Req_addr   = 16'h0000;
        Req_wdata  = 16'h0000;
        #1;
        Rst_n = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_word_store();
        test_word_load();
`ifdef LSU_BYTE_OPS_EN
        test_byte_load();
        test_byte_store();
`else
        test_no_byte_ops();
`endif
        test_reset_mid_op();
        test_back_to_back();
        idle(2);
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_drain: got %0d outstanding expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
